rv_memory_arbiter: RTL

RV_MEMORY_ARBITER -- requirements
Module: rv_memory_arbiter

---
 rtl/rv_memory_pkg.sv | 22 ++
 rtl/rv_round_robin_arbiter.sv | 39 +++
 rtl/rv_memory_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rv_memory_pkg.sv
// rtl/rv_memory_pkg.sv - shared types and helpers for the memory arbiter
package rv_memory_pkg;

    // Arbiter view of the RAM: nothing outstanding, or one read response owed
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } arb_state_t;

    // Bits needed to hold a port index
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rv_round_robin_arbiter.sv
// rtl/rv_round_robin_arbiter.sv - combinational round-robin pick starting after last_grant
module rv_round_robin_arbiter
    import rv_memory_pkg::*;
#(
    parameter int PORTS = 4,
    localparam int IW = clog2(PORTS)
) (
    input  logic [PORTS-1:0] request,
    input  logic [IW-1:0]    last_grant,
    output logic [PORTS-1:0] grant,
    output logic [IW-1:0]    grant_index
);

    int          idx;
    logic [IW-1:0] sel;
    logic        found;

    // Walk the ports from last_grant+1 around to last_grant; first requester wins
    always_comb begin
        grant       = '0;
        grant_index = '0;
        found       = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int off = 1; off <= PORTS; off++) begin
            idx = int'(last_grant) + off;
            if (idx >= PORTS) begin
                idx = idx - PORTS;
            end
            sel = IW'(idx);
            if (!found && request[sel]) begin
                found       = 1'b1;
                grant[sel]  = 1'b1;
                grant_index = sel;
            end
        end
    end

endmodule

// File: rtl/rv_memory_arbiter.sv
// rtl/rv_memory_arbiter.sv - shares one single-port RAM among PORTS requesters (optional RV_MEMORY_ARBITER_LOCK_EN)
module rv_memory_arbiter
    import rv_memory_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [PORTS-1:0]                     req_valid,
    output logic [PORTS-1:0]                     req_ready,
    input  logic [PORTS-1:0]                     req_write_enable,
    input  logic [PORTS-1:0][ADDR_WIDTH-1:0]     req_addr,
    input  logic [PORTS-1:0][DATA_WIDTH-1:0]     req_data,
    output logic [PORTS-1:0]                     resp_valid,
    input  logic [PORTS-1:0]                     resp_ready,
    output logic [DATA_WIDTH-1:0]                resp_data,
`ifdef RV_MEMORY_ARBITER_LOCK_EN
    input  logic [PORTS-1:0]                     req_lock,
`endif
    output logic                                 mem_enable,
    output logic                                 mem_write_enable,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_data_in,
    input  logic [DATA_WIDTH-1:0]                mem_data_out
);

    localparam int            IW         = clog2(PORTS);
    localparam logic [IW-1:0] LAST_RESET = IW'(PORTS - 1);

    arb_state_t      state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last_grant;
    logic [PORTS-1:0] resp_valid_q;

    logic            can_grant;
    logic [PORTS-1:0] arb_request;
    logic [PORTS-1:0] grant;
    logic [IW-1:0]   grant_index;
    logic            grant_valid;

    // A new access may issue when nothing is owed, or the owner drains its response this cycle;
    // held off entirely while reset is asserted
    assign can_grant = rst && ((state == IDLE) || resp_ready[owner]);

`ifdef RV_MEMORY_ARBITER_LOCK_EN
    logic lock_active;
    logic lock_hold;

    // The locked port is always the most recent grant, so last_grant names it
    assign lock_hold = lock_active && req_valid[last_grant];

    // While locked, only the lock holder is offered to the arbiter
    always_comb begin
        arb_request = '0;
        if (can_grant) begin
            if (lock_hold) begin
                arb_request[last_grant] = 1'b1;
            end else begin
                arb_request = req_valid;
            end
        end
    end

    // Lock is taken or released by the req_lock of each grant, and lost if the holder goes away
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_active <= 1'b0;
        end else if (grant_valid) begin
            lock_active <= req_lock[grant_index];
        end else if (lock_active && !req_valid[last_grant]) begin
            lock_active <= 1'b0;
        end
    end
`else
    assign arb_request = can_grant ? req_valid : '0;
`endif

    rv_round_robin_arbiter #(
        .PORTS(PORTS)
    ) u_rr (
        .request    (arb_request),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_index(grant_index)
    );

    assign grant_valid      = |grant;
    assign req_ready        = grant;
    assign mem_enable       = grant_valid;
    assign mem_write_enable = grant_valid && req_write_enable[grant_index];
    assign mem_addr         = req_addr[grant_index];
    assign mem_data_in      = req_data[grant_index];
    assign resp_valid       = resp_valid_q;
    // RAM output holds while mem_enable is low, so it doubles as the response register
    assign resp_data        = mem_data_out;

    // Arbiter FSM: reads open a pending response, drained responses return to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= '0;
            last_grant   <= LAST_RESET;
            resp_valid_q <= '0;
        end else begin
            if (grant_valid) begin
                last_grant <= grant_index;
            end
            if (grant_valid && !req_write_enable[grant_index]) begin
                state        <= PEND;
                owner        <= grant_index;
                resp_valid_q <= grant;
            end else if ((state == PEND) && resp_ready[owner]) begin
                state        <= IDLE;
                resp_valid_q <= '0;
            end
        end
    end

endmodule
